serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits; legal range 2..16.
REQ-002 The block SHALL have port clock, input, 1 bit: single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port minuend, input, WIDTH bits: operand A, sampled with start.
REQ-006 The block SHALL have port subtrahend, input, WIDTH bits: operand B, sampled with start.
REQ-007 The block SHALL have port borrow_in, input, 1 bit: initial borrow, sampled with start.
REQ-008 The block SHALL have port difference, output, WIDTH bits: registered result A - B - borrow_in, modulo 2^WIDTH.
REQ-009 The block SHALL have port borrow_out, output, 1 bit: registered final borrow; 1 when A < B + borrow_in (unsigned).
REQ-010 The block SHALL have port busy, output, 1 bit: high while in SHIFT.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when a new result is on difference and borrow_out.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1 at a clock edge, the block SHALL capture minuend, subtrahend and borrow_in, clear the bit index to 0 and enter SHIFT.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-015 In SHIFT, the block SHALL process one bit per clock, LSB first, at bit index i.
REQ-016 Each SHIFT cycle SHALL compute d[i] = a[i] ^ b[i] ^ br.
REQ-017 Each SHIFT cycle SHALL compute br_next = (~a[i] & b[i]) | (~a[i] & br) | (b[i] & br), and store it as br for the next bit.
REQ-018 The bit index SHALL increment each SHIFT cycle; after bit WIDTH-1 the FSM SHALL enter DONE.
REQ-019 On the edge that enters DONE, the block SHALL load difference with all WIDTH computed bits and borrow_out with the final br.
REQ-020 difference and borrow_out SHALL be updated only on the edge that enters DONE, and SHALL hold their values at all other times, including throughout SHIFT.
REQ-021 Timing SHALL be exact: start accepted at edge N gives busy=1 from edge N through edge N+WIDTH, and done=1 for exactly the one cycle after edge N+WIDTH.
REQ-022 DONE SHALL last exactly one cycle and then unconditionally return to IDLE.
REQ-023 Latency from start acceptance to done SHALL be WIDTH+1 clocks, giving a maximum issue rate of one operation per WIDTH+2 clocks.
REQ-024 start SHALL be ignored in SHIFT and in DONE; no operand capture SHALL occur and the in-flight operation SHALL be unaffected.
REQ-025 Changes to minuend, subtrahend or borrow_in after the start edge SHALL NOT affect the in-flight result.
REQ-026 busy and done SHALL never be high in the same cycle.
REQ-027 The block SHALL handle the wrap-around case: when A < B + borrow_in, difference = (A - B - borrow_in) mod 2^WIDTH and borrow_out = 1.

Reset
REQ-028 reset=1 at a clock edge SHALL force state IDLE, bit index 0, internal borrow 0, difference 0, borrow_out 0, busy 0 and done 0.
REQ-029 reset SHALL take priority over start and over any in-progress operation; an operation interrupted by reset SHALL be discarded with no done pulse.
REQ-030 The first start with reset=0 after reset deasserts SHALL be accepted normally.

Verification
REQ-031 The bench SHALL cover this case: WIDTH=4, A=9, B=3, borrow_in=0 -> done after 5 clocks, difference=6, borrow_out=0.
REQ-032 The bench SHALL cover this case: A=3, B=9, borrow_in=0 -> difference=4'b1010, borrow_out=1.
REQ-033 The bench SHALL cover this case: A=0, B=0, borrow_in=1 -> difference=4'b1111, borrow_out=1; also A=15, B=15, borrow_in=0 -> 0, 0.
REQ-034 The bench SHALL cover this case: start held high for 12 cycles with the operands changed every cycle -> only the first operand set is used, done pulses once per 6 cycles, and results match the captured operands.
REQ-035 The bench SHALL cover this case: reset asserted at the 2nd SHIFT cycle -> no done pulse, all outputs 0, and the next start gives a correct result.
REQ-036 The bench SHALL cover this case: exhaustive check of all 512 combinations of A, B and borrow_in at WIDTH=4 against the reference model; difference and borrow_out SHALL stay stable between done pulses.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - borrow_in one bit per clock, LSB first,
// and presents the registered result with a one-cycle done pulse.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_br;
    logic [WIDTH-1:0] r_dacc;
    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_d;
    logic             w_br_next;
    logic             w_last;
    logic [WIDTH-1:0] w_result;

    always_comb begin
        w_a_bit   = r_a[r_idx];
        w_b_bit   = r_b[r_idx];
        w_d       = w_a_bit ^ w_b_bit ^ r_br;
        w_br_next = (~w_a_bit & w_b_bit) | (~w_a_bit & r_br) | (w_b_bit & r_br);
        w_last    = (r_idx == IDX_W'(WIDTH - 1));
        // Merge the bit being computed this cycle so the result can load on the same edge.
        w_result        = r_dacc;
        w_result[r_idx] = w_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_br       <= 1'b0;
            r_dacc     <= '0;
            difference <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a    <= minuend;
                        r_b    <= subtrahend;
                        r_br   <= borrow_in;
                        r_idx  <= '0;
                        r_dacc <= '0;
                    end
                end
                S_SHIFT: begin
                    r_dacc[r_idx] <= w_d;
                    r_br          <= w_br_next;
                    r_idx         <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        difference <= w_result;
                        borrow_out <= w_br_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
